fft_sequencer: RTL and testbench
================================

// Module: fft_sequencer
// PURPOSE
// Parametrised radix-2 FFT sequencer, successor to the fixed 1024-point stage/pair control.
// Steps through LOG2N stages of N/2 butterfly pairs and issues read, twiddle and write addresses
// for a ping-pong memory pair. Write addresses come from a read-to-write delay line
// matched to the butterfly pipeline. Adds drain between stages, stall, abort and a latched inverse mode.
// Sits between the top-level FFT FSM and the memory/butterfly datapath.
// PARAMETERS
// LOG2N     10  log2 of FFT size; N = 2**LOG2N, pairs per stage = N/2; legal 2..12
// PIPE_LAT  4   cycles from read issue to write of the same pair; legal 1..16
// PORTS
// i_clk          in   1         clock
// i_rst_n        in   1         synchronous reset, active-low
// i_en           in   1         global clock enable; 0 freezes all state
// i_start        in   1         start request, sampled only in IDLE
// i_inverse      in   1         inverse-FFT mode, latched on accepted start
// i_abort        in   1         cancel the run, return to IDLE
// i_stall        in   1         datapath back-pressure; freezes sequencer and delay line
// o_busy         out  1         run in progress (RUN or DRAIN)
// o_done         out  1         1-cycle pulse after the final write of the final stage
// o_stage        out  4         current stage 0..LOG2N-1
// o_rd_valid     out  1         read addresses valid this cycle
// o_rd_addr_a    out  LOG2N     butterfly top read address
// o_rd_addr_b    out  LOG2N     butterfly bottom read address
// o_rd_bank      out  1         memory read from: o_stage[0]
// o_tw_addr      out  LOG2N-1   twiddle ROM index
// o_conj_tw      out  1         latched i_inverse; datapath conjugates twiddle
// o_wr_valid     out  1         write addresses valid this cycle
// o_wr_addr_a    out  LOG2N     top write address (delayed o_rd_addr_a)
// o_wr_addr_b    out  LOG2N     bottom write address
// o_wr_bank      out  1         memory written: inverse of bank read for that pair
// o_last_pair    out  1         high with o_rd_valid for stage LOG2N-1, pair N/2-1
// BEHAVIOUR
// - Reset (i_rst_n=0 at edge): state IDLE, all outputs 0, counters 0, delay line valids cleared.
// - All outputs registered. Advance when i_en=1 and i_stall=0, else hold; o_rd_valid/o_wr_valid forced 0 while i_en=0 or i_stall=1.
// - FSM IDLE -> RUN on i_start (edge 0). First read (stage 0, pair 0) valid in cycle 1; o_busy=1 from cycle 1.
// - RUN: one pair per advancing cycle, pair p = 0..N/2-1. After pair N/2-1 -> DRAIN.
// - DRAIN: PIPE_LAT advancing cycles, no reads, outstanding writes complete.
//   Then stage+1 -> RUN, or after the last stage -> IDLE with o_done=1, o_busy=0 for one cycle.
// - Address math, s = stage:
//   span = 1<<s; a = ((p>>s)<<(s+1)) | (p & (span-1)); b = a + span;
//   tw = (p & (span-1)) << (LOG2N-1-s). Widths truncate to port width; no overflow by construction.
// - Write port: rd {valid,a,b,bank} delayed exactly PIPE_LAT advancing cycles.
//   A stalled cycle neither shifts nor inserts.
// - Timing without stalls: o_done in cycle LOG2N*(N/2+PIPE_LAT)+1.
// - i_start while busy: ignored. i_inverse is sampled only with an accepted start.
// - i_abort, any state except IDLE: next cycle IDLE, outputs 0, delay line cleared, no o_done.
//   Abort beats start in the same cycle. Abort in IDLE: no effect.
// - i_abort is honoured during i_stall (abort overrides freeze). i_rst_n overrides everything, including mid-run.
// TESTING (LOG2N=4, PIPE_LAT=2 unless noted)
// - Start at cycle 0, no stalls -> 32 rd_valid and 32 wr_valid cycles; o_done exactly in cycle 41, once.
// - Address check -> s0 p5: a=10 b=11 tw=0; s1 p3: a=5 b=7 tw=4; s3 p5: a=5 b=13 tw=5; every wr pair equals rd pair 2 cycles later.
// - i_stall high 3 cycles mid-stage 1 -> no valids during stall; sequence resumes unchanged; o_done moves to cycle 44.
// - i_abort at stage 2 pair 4 -> next cycle o_busy=0, no further wr_valid, no o_done; new start runs full 41 cycles.
// - i_start high during run, plus start+abort in the same IDLE cycle -> both ignored; i_inverse=1 at start gives o_conj_tw=1 whole run.
// - Defaults (LOG2N=10, PIPE_LAT=4): o_done in cycle 5161; i_rst_n=0 mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fft_sequencer.sv
// -----------------------------------------------------------------------------
// fft_sequencer
//   Address and control sequencer for an in-place radix-2 FFT over a ping-pong
//   memory pair. Walks LOG2N stages of N/2 butterfly pairs. For each pair it
//   issues top/bottom read addresses and a twiddle index. The same addresses
//   come back out on the write port PIPE_LAT advancing cycles later, matching
//   the butterfly pipeline. Each stage ends with a drain gap of PIPE_LAT
//   cycles so that all of its writes land before the next stage reads.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_en                    global enable, 0 freezes all state
//   i_start / i_inverse     start request (IDLE only), inverse mode latched at start
//   i_abort                 cancel a run and return to IDLE (beats start and stall)
//   i_stall                 datapath back-pressure, freezes sequencer and delay line
//   o_busy, o_done          run in progress, 1-cycle completion pulse
//   o_stage                 current stage
//   o_rd_*                  read valid, addresses, bank, twiddle index, last-pair flag
//   o_conj_tw               latched inverse mode
//   o_wr_*                  write valid, addresses, bank (delayed read pair)
// -----------------------------------------------------------------------------
module fft_sequencer #(
   parameter int LOG2N    = 10,
   parameter int PIPE_LAT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_start,
   input  logic             i_inverse,
   input  logic             i_abort,
   input  logic             i_stall,
   output logic             o_busy,
   output logic             o_done,
   output logic [3:0]       o_stage,
   output logic             o_rd_valid,
   output logic [LOG2N-1:0] o_rd_addr_a,
   output logic [LOG2N-1:0] o_rd_addr_b,
   output logic             o_rd_bank,
   output logic [LOG2N-2:0] o_tw_addr,
   output logic             o_conj_tw,
   output logic             o_wr_valid,
   output logic [LOG2N-1:0] o_wr_addr_a,
   output logic [LOG2N-1:0] o_wr_addr_b,
   output logic             o_wr_bank,
   output logic             o_last_pair
);

   localparam int PW = LOG2N - 1;       // pair counter / twiddle width
   localparam int EW = 2 * LOG2N + 2;   // delay entry: {valid, a, b, bank}

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    pair_q, pair_d;
   logic [3:0]       stage_q, stage_d;
   logic [4:0]       drn_q, drn_d;
   logic             conj_q, conj_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             rd_vld_q, last_q, rd_bank_q;
   logic [LOG2N-1:0] rd_a_q, rd_b_q;
   logic [PW-1:0]    tw_q;
   logic             wr_vld_q, wr_bank_q;
   logic [LOG2N-1:0] wr_a_q, wr_b_q;
   logic [EW-1:0]    dl_q [PIPE_LAT];
   logic [EW-1:0]    dl_tail;

   logic             adv, abort_hit, start_ok, issue;
   logic             pair_last, stage_last, drn_end;
   logic [LOG2N-1:0] p_ext, span, lo_mask, addr_a, addr_b;
   logic [PW-1:0]    tw;

   assign adv        = i_en & ~i_stall;
   assign abort_hit  = i_en & i_abort & (state_q != S_IDLE);
   assign start_ok   = adv & i_start & ~i_abort & (state_q == S_IDLE);
   assign issue      = start_ok | (adv & (state_q == S_RUN));
   assign pair_last  = (pair_q == {PW{1'b1}});
   assign stage_last = (stage_q == 4'(LOG2N - 1));
   // The last stage drains one extra cycle so that o_done lands in the slot
   // where the first read of a following stage would otherwise appear.
   assign drn_end    = stage_last ? (drn_q == 5'(PIPE_LAT)) : (drn_q == 5'(PIPE_LAT - 1));
   assign dl_tail    = dl_q[PIPE_LAT-1];

   // Butterfly addressing: a inserts a 0 at bit s of the pair index, b sets it.
   // In IDLE pair_q and stage_q are 0, so the start cycle issues pair 0 of stage 0.
   always_comb begin
      p_ext   = {1'b0, pair_q};
      span    = LOG2N'(1) << stage_q;
      lo_mask = span - LOG2N'(1);
      addr_a  = ((p_ext >> stage_q) << (stage_q + 4'd1)) | (p_ext & lo_mask);
      addr_b  = addr_a | span;
      tw      = PW'(p_ext & lo_mask) << (4'(LOG2N - 1) - stage_q);
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (abort_hit) begin
         state_d = S_IDLE;
      end else if (adv) begin
         case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (pair_last) state_d = S_DRAIN;
            S_DRAIN: if (drn_end) state_d = stage_last ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output / counter next values
   always_comb begin
      pair_d  = pair_q;
      stage_d = stage_q;
      drn_d   = drn_q;
      conj_d  = conj_q;
      done_d  = 1'b0;
      if (start_ok) conj_d = i_inverse;
      if (issue) pair_d = pair_q + PW'(1);
      if (adv && (state_q == S_DRAIN)) begin
         if (drn_end) begin
            drn_d   = '0;
            stage_d = stage_last ? 4'd0 : stage_q + 4'd1;
            done_d  = stage_last;
         end else begin
            drn_d = drn_q + 5'd1;
         end
      end
      busy_d = (state_d != S_IDLE);
   end

   // Counters, read/write output registers and the read-to-write delay line.
   // Non-advancing cycles hold everything but force both valids low.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || abort_hit) begin
         pair_q    <= '0;
         stage_q   <= '0;
         drn_q     <= '0;
         conj_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         last_q    <= 1'b0;
         rd_a_q    <= '0;
         rd_b_q    <= '0;
         rd_bank_q <= 1'b0;
         tw_q      <= '0;
         wr_vld_q  <= 1'b0;
         wr_a_q    <= '0;
         wr_b_q    <= '0;
         wr_bank_q <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
      end else begin
         pair_q   <= pair_d;
         stage_q  <= stage_d;
         drn_q    <= drn_d;
         conj_q   <= conj_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rd_vld_q <= issue;
         last_q   <= issue & pair_last & stage_last;
         wr_vld_q <= adv & dl_tail[EW-1];
         if (issue) begin
            rd_a_q    <= addr_a;
            rd_b_q    <= addr_b;
            rd_bank_q <= stage_q[0];
            tw_q      <= tw;
         end
         if (adv) begin
            dl_q[0] <= {issue, addr_a, addr_b, stage_q[0]};
            for (int i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
            if (dl_tail[EW-1]) begin
               wr_a_q    <= dl_tail[2*LOG2N:LOG2N+1];
               wr_b_q    <= dl_tail[LOG2N:1];
               wr_bank_q <= ~dl_tail[0];
            end
         end
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_stage     = stage_q;
   assign o_rd_valid  = rd_vld_q;
   assign o_rd_addr_a = rd_a_q;
   assign o_rd_addr_b = rd_b_q;
   assign o_rd_bank   = rd_bank_q;
   assign o_tw_addr   = tw_q;
   assign o_conj_tw   = conj_q;
   assign o_wr_valid  = wr_vld_q;
   assign o_wr_addr_a = wr_a_q;
   assign o_wr_addr_b = wr_b_q;
   assign o_wr_bank   = wr_bank_q;
   assign o_last_pair = last_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_sequencer
//   Scoreboard bench for fft_sequencer. A small N=16 / PIPE_LAT=2 instance is
//   driven by directed runs; expected read/write/done events are queued when a
//   run is started and a negedge monitor pops them as the DUT presents them.
//   A second instance with default parameters checks full-size timing and
//   mid-run reset.
// -----------------------------------------------------------------------------
module tb_fft_sequencer;

   localparam int LN = 4;
   localparam int PL = 2;
   localparam int NH = 8;          // pairs per stage
   localparam int SP = NH + PL;    // advancing cycles per stage

   typedef struct { int t; int stg; int a; int b; int tw; int bank; int last; int conj; } rd_t;
   typedef struct { int t; int a; int b; int bank; } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic          rst_n, en, start, inverse, abort, stall;
   logic          busy, done, rd_valid, rd_bank, conj_tw, wr_valid, wr_bank, last_pair;
   logic [3:0]    stage;
   logic [LN-1:0] rd_a, rd_b, wr_a, wr_b;
   logic [LN-2:0] tw;

   // default-size instance
   logic          d_rst_n, d_en, d_start, d_inverse, d_abort, d_stall;
   logic          d_busy, d_done, d_rd_valid, d_rd_bank, d_conj_tw, d_wr_valid, d_wr_bank, d_last_pair;
   logic [3:0]    d_stage;
   logic [9:0]    d_rd_a, d_rd_b, d_wr_a, d_wr_b;
   logic [8:0]    d_tw;

   fft_sequencer #(.LOG2N(LN), .PIPE_LAT(PL)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_inverse(inverse),
      .i_abort(abort), .i_stall(stall), .o_busy(busy), .o_done(done), .o_stage(stage),
      .o_rd_valid(rd_valid), .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_rd_bank(rd_bank),
      .o_tw_addr(tw), .o_conj_tw(conj_tw), .o_wr_valid(wr_valid), .o_wr_addr_a(wr_a),
      .o_wr_addr_b(wr_b), .o_wr_bank(wr_bank), .o_last_pair(last_pair));

   fft_sequencer dut_def (
      .i_clk(clk), .i_rst_n(d_rst_n), .i_en(d_en), .i_start(d_start), .i_inverse(d_inverse),
      .i_abort(d_abort), .i_stall(d_stall), .o_busy(d_busy), .o_done(d_done), .o_stage(d_stage),
      .o_rd_valid(d_rd_valid), .o_rd_addr_a(d_rd_a), .o_rd_addr_b(d_rd_b), .o_rd_bank(d_rd_bank),
      .o_tw_addr(d_tw), .o_conj_tw(d_conj_tw), .o_wr_valid(d_wr_valid), .o_wr_addr_a(d_wr_a),
      .o_wr_addr_b(d_wr_b), .o_wr_bank(d_wr_bank), .o_last_pair(d_last_pair));

   int  total = 0;
   int  bad   = 0;
   int  ecnt  = 0;     // posedges seen
   int  acnt  = 0;     // advancing posedges of the small instance
   bit  last_adv = 1'b1;

   rd_t rdq[$];
   wr_t wrq[$];
   int  doneq[$];

   int  rd_seen = 0, wr_seen = 0, done_seen = 0, done_ecnt = 0;
   int  log_a[$], log_b[$], log_tw[$];
   int  d_rd = 0, d_wr = 0, d_done_n = 0, d_done_ecnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      ecnt++;
      last_adv = en & ~stall;
      if (en && !stall) acnt++;
   end

   // Scoreboard monitor for the small instance
   always @(negedge clk) begin
      if (!last_adv) begin
         chk("stall_rd_valid", rd_valid, 0);
         chk("stall_wr_valid", wr_valid, 0);
      end
      if (rd_valid === 1'b1) begin
         rd_seen++;
         log_a.push_back(int'(rd_a));
         log_b.push_back(int'(rd_b));
         log_tw.push_back(int'(tw));
         if (rdq.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            rd_t e;
            e = rdq.pop_front();
            chk("rd_time", acnt, e.t);
            chk("rd_stage", stage, e.stg);
            chk("rd_a", rd_a, e.a);
            chk("rd_b", rd_b, e.b);
            chk("rd_tw", tw, e.tw);
            chk("rd_bank", rd_bank, e.bank);
            chk("rd_last", last_pair, e.last);
            chk("rd_conj", conj_tw, e.conj);
         end
      end else begin
         chk("last_without_rd", last_pair, 0);
      end
      if (wr_valid === 1'b1) begin
         wr_seen++;
         if (wrq.size() == 0) begin
            chk("wr_unexpected", 1, 0);
         end else begin
            wr_t w;
            w = wrq.pop_front();
            chk("wr_time", acnt, w.t);
            chk("wr_a", wr_a, w.a);
            chk("wr_b", wr_b, w.b);
            chk("wr_bank", wr_bank, w.bank);
         end
      end
      if (done === 1'b1) begin
         done_seen++;
         done_ecnt = ecnt;
         if (doneq.size() == 0) chk("done_unexpected", 1, 0);
         else chk("done_time", acnt, doneq.pop_front());
      end
   end

   // Event counter for the default-size instance
   always @(negedge clk) begin
      if (d_rd_valid === 1'b1) d_rd++;
      if (d_wr_valid === 1'b1) d_wr++;
      if (d_done === 1'b1) begin
         d_done_n++;
         d_done_ecnt = ecnt;
      end
   end

   // Textbook group/offset enumeration of one complete run.
   task automatic push_run(input int a0, input int cj);
      for (int s = 0; s < LN; s++) begin
         int span;
         span = 1 << s;
         for (int g = 0; g < NH / span; g++) begin
            for (int j = 0; j < span; j++) begin
               rd_t r;
               wr_t w;
               int  p;
               p      = g * span + j;
               r.t    = a0 + s * SP + p + 1;
               r.stg  = s;
               r.a    = g * 2 * span + j;
               r.b    = r.a + span;
               r.tw   = j * (NH / span);
               r.bank = s % 2;
               r.last = (s == LN - 1 && p == NH - 1) ? 1 : 0;
               r.conj = cj;
               rdq.push_back(r);
               w.t    = r.t + PL;
               w.a    = r.a;
               w.b    = r.b;
               w.bank = 1 - r.bank;
               wrq.push_back(w);
            end
         end
      end
      doneq.push_back(a0 + LN * SP + 1);
   endtask

   // Called at posedge+1; returns with the start edge taken (cycle 1).
   task automatic start_run(input int inv, output int t0);
      push_run(acnt, inv);
      t0      = ecnt;
      start   = 1'b1;
      inverse = inv[0];
      @(posedge clk); #1;
      start   = 1'b0;
      inverse = ~inv[0];
      chk("busy_cycle1", busy, 1);
   endtask

   task automatic wait_to(input int t0, input int c);
      while (ecnt - t0 < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_empty(input string nm, input int lim);
      int n;
      n = 0;
      while ((rdq.size() + wrq.size() + doneq.size()) != 0 && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk); #1;
      chk(nm, rdq.size() + wrq.size() + doneq.size(), 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] small_outs();
      return {33'b0, busy, done, stage, rd_valid, rd_a, rd_b, rd_bank, tw, conj_tw,
              wr_valid, wr_a, wr_b, wr_bank, last_pair};
   endfunction

   initial begin
      int t0, b_rd, b_wr, b_done, b_log, dn, n;
      rst_n = 1'b0; en = 1'b1; start = 1'b0; inverse = 1'b0; abort = 1'b0; stall = 1'b0;
      d_rst_n = 1'b0; d_en = 1'b1; d_start = 1'b0; d_inverse = 1'b0; d_abort = 1'b0; d_stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", small_outs(), 0);
      chk("reset_busy_def", d_busy, 0);
      rst_n = 1'b1; d_rst_n = 1'b1;
      @(posedge clk); #1;

      // plain run
      b_rd = rd_seen; b_wr = wr_seen; b_done = done_seen; b_log = log_a.size();
      start_run(0, t0);
      wait_empty("run1_complete", 100);
      chk("run1_rd_count", rd_seen - b_rd, 32);
      chk("run1_wr_count", wr_seen - b_wr, 32);
      chk("run1_done_count", done_seen - b_done, 1);
      chk("run1_done_cycle", done_ecnt - t0, 41);
      chk("s0p5_a", log_a[b_log + 5], 10);
      chk("s0p5_b", log_b[b_log + 5], 11);
      chk("s0p5_tw", log_tw[b_log + 5], 0);
      chk("s1p3_a", log_a[b_log + 11], 5);
      chk("s1p3_b", log_b[b_log + 11], 7);
      chk("s1p3_tw", log_tw[b_log + 11], 4);
      chk("s3p5_a", log_a[b_log + 29], 5);
      chk("s3p5_b", log_b[b_log + 29], 13);
      chk("s3p5_tw", log_tw[b_log + 29], 5);
      repeat (5) @(posedge clk);
      #1;
      chk("run1_single_done", done_seen - b_done, 1);
      chk("run1_idle_busy", busy, 0);

      // three stalled cycles in stage 1
      b_rd = rd_seen;
      start_run(0, t0);
      wait_to(t0, 13);
      stall = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stall = 1'b0;
      wait_empty("stall_complete", 100);
      chk("stall_rd_count", rd_seen - b_rd, 32);
      chk("stall_done_cycle", done_ecnt - t0, 44);

      // abort at stage 2 pair 4, then a fresh full run
      b_done = done_seen;
      start_run(0, t0);
      wait_to(t0, 25);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      rdq.delete(); wrq.delete(); doneq.delete();
      chk("abort_outputs", small_outs(), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", done_seen - b_done, 0);
      start_run(0, t0);
      wait_empty("after_abort_complete", 100);
      chk("after_abort_done_cycle", done_ecnt - t0, 41);

      // start+abort together in IDLE, then inverse run with start held mid-run
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle_busy", busy, 0);
      repeat (5) @(posedge clk);
      #1;
      start_run(1, t0);
      wait_to(t0, 5);
      start = 1'b1;
      wait_to(t0, 15);
      start = 1'b0;
      wait_empty("inverse_complete", 100);
      chk("inverse_done_cycle", done_ecnt - t0, 41);

      // default parameters: full timing, then reset mid-run
      dn = d_done_n; b_rd = d_rd; b_wr = d_wr;
      t0 = ecnt;
      d_start = 1'b1;
      @(posedge clk); #1;
      d_start = 1'b0;
      n = 0;
      while (d_done_n == dn && n < 6000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("def_done_seen", d_done_n - dn, 1);
      chk("def_done_cycle", d_done_ecnt - t0, 5161);
      chk("def_rd_count", d_rd - b_rd, 5120);
      chk("def_wr_count", d_wr - b_wr, 5120);
      d_start = 1'b1;
      @(posedge clk); #1;
      d_start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("def_busy_midrun", d_busy, 1);
      d_rst_n = 1'b0;
      @(posedge clk); #1;
      d_rst_n = 1'b1;
      chk("def_reset_outputs",
          {3'b0, d_busy, d_done, d_stage, d_rd_valid, d_rd_a, d_rd_b, d_rd_bank, d_tw, d_conj_tw,
           d_wr_valid, d_wr_a, d_wr_b, d_wr_bank, d_last_pair}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
